// File: rtl/eth_pkg.sv
// Shared Ethernet constants and the transmit framer state encoding.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
    localparam logic [7:0]  ETH_SFD         = 8'hD5;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_DATA     = 3'd3,
        ST_PAD      = 3'd4,
        ST_FCS      = 3'd5,
        ST_IFG      = 3'd6,
        ST_DRAIN    = 3'd7
    } framer_state_t;

endpackage

// File: rtl/eth_tx_framer_if.sv
// Word-side handshake from the packet builder plus the byte-wide PHY side of the framer.
interface eth_tx_framer_if;
    import eth_pkg::*;

    // A word moves on a clock edge where i_vld && o_rdy; i_sop/i_eop/i_data are qualified by i_vld
    // and must stay stable until that edge.
    logic [31:0]   i_data;
    logic          i_vld;
    logic          i_sop;
    logic          i_eop;
    logic          o_rdy;
    logic [7:0]    o_txd;
    logic          o_tx_en;
    logic          o_tx_er;
    logic          o_busy;
    logic          o_frame_done;
    logic          o_underrun;
    framer_state_t state_dbg;

    modport master (
        output i_data, i_vld, i_sop, i_eop,
        input  o_rdy, o_txd, o_tx_en, o_tx_er, o_busy, o_frame_done, o_underrun, state_dbg
    );

    modport slave (
        input  i_data, i_vld, i_sop, i_eop,
        output o_rdy, o_txd, o_tx_en, o_tx_er, o_busy, o_frame_done, o_underrun, state_dbg
    );

endinterface

// File: rtl/eth_crc32_d8.sv
// One-byte step of the reflected Ethernet CRC32 (LSB of the byte enters first).
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  byte_in,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h000000, byte_in};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/eth_tx_framer.sv
// Turns the 32-bit packet-builder word stream into a GMII byte stream with preamble, pad, FCS and IFG.
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int IFG_BYTES    = 12,
    parameter int SOP_SKIP     = 2
) (
    input  logic clk,
    input  logic rst,
    eth_tx_framer_if.slave bus
);

    framer_state_t state;
    logic [7:0]    cnt;
    logic [31:0]   sh;
    logic [1:0]    rem;
    logic          last_q;
    logic [10:0]   byte_cnt;
    logic [31:0]   crc_q;
    logic [31:0]   crc_nxt;
    logic [7:0]    data_byte;
    logic [31:0]   sop_word;
    logic          rdy;
    logic          start_ok;
    logic          pad_more;
    logic [7:0]    txd;
    logic          tx_en;
    logic          tx_er;
    logic          busy;
    logic          frame_done;
    logic          underrun;

    assign sop_word = bus.i_data << (8 * SOP_SKIP);
    assign pad_more = byte_cnt < 11'(MIN_FRAME);
    assign start_ok = bus.i_vld && bus.i_sop &&
                      ((state == ST_IDLE) || (state == ST_IFG && cnt == 8'(IFG_BYTES - 1)));

    // o_rdy decodes the byte currently on o_txd: a word is taken during the last byte of the previous one.
    always_comb begin
        rdy = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE:  rdy = bus.i_vld && !bus.i_sop;
                ST_SFD:   rdy = 1'b1;
                ST_DATA:  rdy = (rem == 2'd0) && !last_q;
                ST_DRAIN: rdy = 1'b1;
                default:  rdy = 1'b0;
            endcase
        end
    end

    always_comb begin
        data_byte = 8'h00;
        case (state)
            ST_SFD:  data_byte = sop_word[31:24];
            ST_DATA: begin
                if (rem != 2'd0)  data_byte = sh[31:24];
                else if (!last_q) data_byte = bus.i_data[31:24];
            end
            default: data_byte = 8'h00;
        endcase
    end

    eth_crc32_d8 u_crc (
        .crc_in  (crc_q),
        .byte_in (data_byte),
        .crc_out (crc_nxt)
    );

    // state names the kind of byte currently on o_txd; each branch registers the following byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= 8'd0;
            sh         <= 32'h0;
            rem        <= 2'd0;
            last_q     <= 1'b0;
            byte_cnt   <= 11'd0;
            crc_q      <= 32'hFFFFFFFF;
            txd        <= 8'h00;
            tx_en      <= 1'b0;
            tx_er      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            tx_er      <= 1'b0;
            if (start_ok) begin
                state    <= ST_PREAMBLE;
                txd      <= ETH_PREAMBLE;
                tx_en    <= 1'b1;
                busy     <= 1'b1;
                cnt      <= 8'd0;
                crc_q    <= 32'hFFFFFFFF;
                byte_cnt <= 11'd0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        txd   <= 8'h00;
                        tx_en <= 1'b0;
                    end
                    ST_PREAMBLE: begin
                        if (cnt == 8'(PREAMBLE_LEN - 1)) begin
                            state <= ST_SFD;
                            txd   <= ETH_SFD;
                        end else begin
                            cnt <= cnt + 8'd1;
                            txd <= ETH_PREAMBLE;
                        end
                    end
                    ST_SFD: begin
                        state    <= ST_DATA;
                        txd      <= data_byte;
                        sh       <= {sop_word[23:0], 8'h00};
                        rem      <= 2'(3 - SOP_SKIP);
                        last_q   <= bus.i_eop;
                        crc_q    <= crc_nxt;
                        byte_cnt <= byte_cnt + 11'd1;
                    end
                    ST_DATA: begin
                        if (rem != 2'd0) begin
                            txd      <= data_byte;
                            sh       <= sh << 8;
                            rem      <= rem - 2'd1;
                            crc_q    <= crc_nxt;
                            byte_cnt <= byte_cnt + 11'd1;
                        end else if (last_q) begin
                            if (pad_more) begin
                                state    <= ST_PAD;
                                txd      <= 8'h00;
                                crc_q    <= crc_nxt;
                                byte_cnt <= byte_cnt + 11'd1;
                            end else begin
                                state <= ST_FCS;
                                txd   <= ~crc_q[7:0];
                                sh    <= {8'h00, ~crc_q[31:8]};
                                cnt   <= 8'd0;
                            end
                        end else if (bus.i_vld) begin
                            txd      <= data_byte;
                            sh       <= {bus.i_data[23:0], 8'h00};
                            rem      <= 2'd3;
                            last_q   <= bus.i_eop;
                            crc_q    <= crc_nxt;
                            byte_cnt <= byte_cnt + 11'd1;
                        end else begin
                            // Builder missed its slot: flag one errored byte, then swallow the rest.
                            state    <= ST_DRAIN;
                            txd      <= 8'h00;
                            tx_er    <= 1'b1;
                            underrun <= 1'b1;
                        end
                    end
                    ST_PAD: begin
                        if (pad_more) begin
                            txd      <= 8'h00;
                            crc_q    <= crc_nxt;
                            byte_cnt <= byte_cnt + 11'd1;
                        end else begin
                            state <= ST_FCS;
                            txd   <= ~crc_q[7:0];
                            sh    <= {8'h00, ~crc_q[31:8]};
                            cnt   <= 8'd0;
                        end
                    end
                    ST_FCS: begin
                        if (cnt == 8'd3) begin
                            state <= ST_IFG;
                            txd   <= 8'h00;
                            tx_en <= 1'b0;
                            cnt   <= 8'd0;
                        end else begin
                            txd        <= sh[7:0];
                            sh         <= sh >> 8;
                            cnt        <= cnt + 8'd1;
                            frame_done <= (cnt == 8'd2);
                        end
                    end
                    ST_IFG: begin
                        if (cnt == 8'(IFG_BYTES - 1)) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    ST_DRAIN: begin
                        txd   <= 8'h00;
                        tx_en <= 1'b0;
                        if (bus.i_vld && bus.i_eop) begin
                            state <= ST_IFG;
                            cnt   <= 8'd0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.o_rdy        = rdy;
    assign bus.o_txd        = txd;
    assign bus.o_tx_en      = tx_en;
    assign bus.o_tx_er      = tx_er;
    assign bus.o_busy       = busy;
    assign bus.o_frame_done = frame_done;
    assign bus.o_underrun   = underrun;
    assign bus.state_dbg    = state;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Random-data frame bench for eth_tx_framer against a byte-level frame model with a table CRC.
module tb_eth_tx_framer;
  import eth_pkg::*;

  localparam int BUDGET = 4000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  eth_tx_framer_if bus ();

  eth_tx_framer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  int n_to  = 0;

  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  logic [31:0] wq[$];
  logic [31:0] crc_tbl[256];

  int   txen_cyc = 0, er_cyc = 0, urun_cnt = 0, fd_cnt = 0, hs_cnt = 0;
  int   rise_cnt = 0, busy_cyc = 0, last_gap = 0, zero_run = 0, fd_pos = 0;
  logic prev_en = 1'b0;
  int   frame_cyc;
  logic aborted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (bus.o_tx_en) begin
        got_q.push_back(bus.o_txd);
        txen_cyc++;
        if (!prev_en) begin
          rise_cnt++;
          last_gap = zero_run;
        end
        zero_run = 0;
      end else begin
        zero_run++;
      end
      prev_en = bus.o_tx_en;
      if (bus.o_tx_er) er_cyc++;
      if (bus.o_underrun) urun_cnt++;
      if (bus.o_frame_done) begin
        fd_cnt++;
        fd_pos = got_q.size();
      end
      if (bus.o_rdy && bus.i_vld) hs_cnt++;
      if (bus.o_busy) busy_cyc++;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [7:0] idx;
    idx = c[7:0] ^ b;
    return crc_tbl[idx] ^ (c >> 8);
  endfunction

  // Appends the complete expected PHY byte sequence for the words in wq.
  task automatic model_frame();
    logic [7:0]  fb[$];
    logic [31:0] c;
    logic [31:0] w;
    fb = {};
    w = wq[0];
    fb.push_back(w[15:8]);
    fb.push_back(w[7:0]);
    for (int i = 1; i < wq.size(); i++) begin
      w = wq[i];
      for (int b = 3; b >= 0; b--) fb.push_back(w[8*b +: 8]);
    end
    while (fb.size() < 60) fb.push_back(8'h00);
    c = 32'hFFFFFFFF;
    foreach (fb[i]) c = crc_byte(c, fb[i]);
    c = ~c;
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    foreach (fb[i]) exp_q.push_back(fb[i]);
    for (int b = 0; b < 4; b++) exp_q.push_back(c[8*b +: 8]);
  endtask

  task automatic gen_words(input int n);
    wq = {};
    for (int i = 0; i < n; i++) wq.push_back($urandom);
  endtask

  // ---------------- driver ----------------
  task automatic wait_rdy(input int rst_at);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.o_tx_en) frame_cyc++;
      if (rst_at >= 0 && frame_cyc == rst_at + 1) begin
        rst = 1'b1;
        aborted = 1'b1;
        return;
      end
      if (bus.o_rdy) break;
      n++;
      if (n > BUDGET) begin
        n_to++;
        aborted = 1'b1;
        return;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int gap_word, input int rst_at);
    frame_cyc = 0;
    aborted = 1'b0;
    for (int k = 0; k < wq.size(); k++) begin
      if (k == gap_word) begin
        bus.i_vld = 1'b0;
        wait_rdy(-1);
      end
      bus.i_data = wq[k];
      bus.i_vld  = 1'b1;
      bus.i_sop  = (k == 0);
      bus.i_eop  = (k == wq.size() - 1);
      wait_rdy(rst_at);
      if (aborted) break;
    end
    bus.i_vld = 1'b0;
    bus.i_sop = 1'b0;
    bus.i_eop = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bus.o_busy || bus.o_tx_en) && n < BUDGET);
    if (n >= BUDGET) n_to++;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic cmp_stream(input string tag, input int base);
    int n;
    int nbad;
    n = got_q.size() - base;
    nbad = 0;
    for (int i = 0; i < n && i < exp_q.size(); i++)
      if (got_q[base + i] !== exp_q[i]) nbad++;
    check({tag, "_len"}, n, exp_q.size());
    check({tag, "_bad_bytes"}, nbad, 0);
  endtask

  task automatic run_simple(input int nw, input string tag);
    int base, fd0, hs0, er0, rise0;
    gen_words(nw);
    exp_q = {};
    model_frame();
    base = got_q.size(); fd0 = fd_cnt; hs0 = hs_cnt; er0 = er_cyc; rise0 = rise_cnt;
    send_frame(-1, -1);
    wait_idle();
    cmp_stream(tag, base);
    check({tag, "_done_cnt"}, fd_cnt - fd0, 1);
    check({tag, "_done_pos"}, fd_pos - base, exp_q.size());
    check({tag, "_hs"}, hs_cnt - hs0, nw);
    check({tag, "_tx_er"}, er_cyc - er0, 0);
    check({tag, "_bursts"}, rise_cnt - rise0, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_txd"}, bus.o_txd, 0);
    check({tag, "_tx_en"}, bus.o_tx_en, 0);
    check({tag, "_tx_er"}, bus.o_tx_er, 0);
    check({tag, "_busy"}, bus.o_busy, 0);
    check({tag, "_rdy"}, bus.o_rdy, 0);
    check({tag, "_done"}, bus.o_frame_done, 0);
    check({tag, "_urun"}, bus.o_underrun, 0);
    check({tag, "_state"}, 32'(bus.state_dbg), 32'(ST_IDLE));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete in time");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] c;
    logic [31:0] wa[$];
    logic [31:0] wb[$];
    int base, hs0, en0, busy0, er0, ur0, fd0, rise0, b0;

    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
      crc_tbl[i] = c;
    end

    rst = 1'b1;
    bus.i_data = '0;
    bus.i_vld  = 1'b0;
    bus.i_sop  = 1'b0;
    bus.i_eop  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // ARP-size frame: 42 bytes, 18 pad
    base = got_q.size(); en0 = txen_cyc;
    run_simple(11, "t1_arp");
    check("t1_tx_en_cycles", txen_cyc - en0, 72);
    check("t1_pad_bytes", got_q.size() - base - 8 - 4 - 42, 18);

    // Long UDP frame: no pad, FCS residue at the receiver
    base = got_q.size(); en0 = txen_cyc;
    run_simple(361, "t2_udp");
    check("t2_tx_en_cycles", txen_cyc - en0, 1454);
    c = 32'hFFFFFFFF;
    for (int i = base + 8; i < got_q.size(); i++) c = crc_byte(c, got_q[i]);
    check("t2_residue", c, CRC32_RESIDUE);

    // Back-to-back frames with the second sop waiting through the gap
    gen_words(5);
    exp_q = {};
    model_frame();
    wa = wq;
    gen_words(17);
    model_frame();
    wb = wq;
    base = got_q.size(); fd0 = fd_cnt; rise0 = rise_cnt;
    wq = wa;
    send_frame(-1, -1);
    wq = wb;
    send_frame(-1, -1);
    wait_idle();
    cmp_stream("t3_b2b", base);
    check("t3_gap", last_gap, 12);
    check("t3_done_cnt", fd_cnt - fd0, 2);
    check("t3_bursts", rise_cnt - rise0, 2);

    // Underrun at word 5 of a 20-word frame
    gen_words(20);
    exp_q = {};
    model_frame();
    exp_q = exp_q[0:25];
    exp_q.push_back(8'h00);
    base = got_q.size(); hs0 = hs_cnt; er0 = er_cyc; ur0 = urun_cnt; fd0 = fd_cnt;
    send_frame(5, -1);
    b0 = busy_cyc;
    wait_idle();
    cmp_stream("t4_urun", base);
    check("t4_underrun", urun_cnt - ur0, 1);
    check("t4_tx_er", er_cyc - er0, 1);
    check("t4_er_last_byte", got_q[got_q.size() - 1], 8'h00);
    check("t4_drained_hs", hs_cnt - hs0, 20);
    check("t4_ifg_busy", busy_cyc - b0, 12);
    check("t4_no_done", fd_cnt - fd0, 0);

    // Reset at T30 of a frame, then a clean restart
    gen_words(20);
    exp_q = {};
    model_frame();
    exp_q = exp_q[0:30];
    base = got_q.size(); busy0 = busy_cyc;
    send_frame(-1, 30);
    @(negedge clk);
    check_outputs_zero("t5_in_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp_stream("t5_cut", base);
    run_simple(4, "t5_restart");

    // Stray non-sop words in IDLE
    hs0 = hs_cnt; en0 = txen_cyc; busy0 = busy_cyc;
    for (int i = 0; i < 4; i++) begin
      bus.i_data = $urandom;
      bus.i_vld  = 1'b1;
      bus.i_sop  = 1'b0;
      bus.i_eop  = (i == 3);
      wait_rdy(-1);
    end
    bus.i_vld = 1'b0;
    bus.i_eop = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("t6_stray_hs", hs_cnt - hs0, 4);
    check("t6_stray_tx", txen_cyc - en0, 0);
    check("t6_stray_busy", busy_cyc - busy0, 0);

    // Pad boundary and random-length frames
    run_simple(1, "single_word");
    run_simple(15, "pad_58");
    run_simple(16, "no_pad_62");
    for (int r = 0; r < 6; r++) run_simple($urandom_range(1, 30), "rand");

    check("timeouts", n_to, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
